digit_scan_sequencer: RTL and testbench
=======================================

Name: digit_scan_sequencer

Overview:
Generates the 2-bit select index that drives the 2-to-4 decoder stage for time-multiplexed 4-digit scanning. It steps through enabled digit positions, holding each one for a programmable number of clock cycles and skipping masked positions. It flags frame completion so downstream logic can update display data between frames. The select output connects directly to the decoder's 2-bit input.

Parameters:
PRESCALE, 4, dwell time in clock cycles per digit position; legal range 1..65535.
CNT_W, 16, dwell counter width; must satisfy 2**CNT_W >= PRESCALE.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; low forces IDLE
digit_mask  input  4  bit k=1 means position k takes part in the scan
sel  output  2  current digit index, feeds decoder input
sel_valid  output  1  sel is meaningful; decoder output is qualified by this
frame_done  output  1  one-cycle pulse, coincident with the sel value produced by a wrap

Behaviour:
- Reset is asynchronous, active-low. All registers clear immediately while rst_n=0.
  - Values during reset: state=IDLE, sel=0, sel_valid=0, frame_done=0, dwell cnt=0.
  - Release is synchronous to the next clk edge.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, SCAN.
- IDLE:
  - sel=0, sel_valid=0, cnt held at 0.
  - Exit when en=1 and digit_mask!=0. Next cycle: state=SCAN, sel=lowest set bit of digit_mask, sel_valid=1, cnt=0, frame_done=0.
- SCAN, normal operation:
  - cnt increments each cycle.
  - When cnt==PRESCALE-1: cnt<=0 and sel<=next enabled index.
  - Next enabled index = circular search starting at sel+1 (mod 4), over 4 positions including the current one.
- Wrap detection:
  - A wrap occurs when the new sel <= the old sel numerically.
  - frame_done=1 in the same cycle the wrapped sel appears; 0 otherwise.
- Single enabled digit: sel is unchanged, and every advance is a wrap. frame_done pulses once every PRESCALE cycles.
- PRESCALE=1: advance every cycle. There are no idle cycles between positions.
- Current digit masked mid-dwell (digit_mask[sel]=0 while other bits are set):
  - Forced advance in the next cycle, regardless of cnt.
  - cnt<=0; wrap rule applies to frame_done.
- SCAN->IDLE when en=0 or digit_mask==0, with priority over advance.
  - Next cycle: sel=0, sel_valid=0, frame_done=0, cnt=0.
- Re-entry from IDLE always restarts at the lowest enabled digit with a full dwell. There is no resume.
- Mask changes that leave the current digit enabled take effect at the next normal advance only.
- Counter arithmetic is unsigned CNT_W bits. cnt never exceeds PRESCALE-1.

Decomposition:
- Shared package holds:
  - NUM_DIGITS=4 and SEL_W=2 (shared with the decoder stage).
  - State encoding IDLE=1'b0, SCAN=1'b1.
  - next-enabled-index function: input sel and mask, output index plus wrap flag.
- One sub-module is natural: dwell_prescaler.
  - Inputs: clk, rst_n, clear, run.
  - Output: tick, high when cnt==PRESCALE-1.
  - Parameterised by PRESCALE and CNT_W.
- The top level holds the FSM, sel register and frame_done register.

Test Plan:
All scenarios use PRESCALE=4 unless stated otherwise.
1. Reset, then en=1, mask=4'b1111 -> sel_valid=1 one cycle after the en edge; sel=0,1,2,3, each held 4 cycles; sel returns to 0 at cycle 17 with frame_done=1 for that single cycle only.
2. mask=4'b1010 -> sel sequence 1,3,1,3, 4 cycles each; frame_done pulses on each return to 1 (every 8 cycles).
3. mask=4'b0100 -> sel constant 2, sel_valid=1; frame_done pulses every 4 cycles. Repeat with PRESCALE=1 -> frame_done high every cycle.
4. Scanning with sel=1 at cnt=1; set mask 4'b1111->4'b1101 -> next cycle sel=2, cnt=0, frame_done=0; sel=2 then dwells a full 4 cycles.
5. en dropped mid-dwell at sel=3 -> next cycle sel=0, sel_valid=0. en reasserted with mask=4'b1000 -> next cycle sel=3, sel_valid=1, full dwell.
6. rst_n pulled low asynchronously mid-dwell (between edges) -> sel=0, sel_valid=0, frame_done=0 immediately. After release with en=1 and mask=4'b1111 -> restart at sel=0 on the first edge.

Source files
------------

// File: rtl/digit_scan_sequencer_pkg.sv
// Shared definitions for the digit scan path (sequencer and 2-to-4 decoder stage).
// No logic of its own; the search helper is combinational.
// No flow control.
package digit_scan_sequencer_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] idx;
        logic             wrap;
    } next_sel_t;

    // Circular search from sel+1; the current position is the last candidate,
    // so a single enabled digit maps onto itself and counts as a wrap.
    function automatic next_sel_t next_enabled(input logic [SEL_W-1:0]      sel,
                                               input logic [NUM_DIGITS-1:0] mask);
        next_sel_t        r;
        logic             found;
        logic [SEL_W-1:0] cand;
        r.idx  = sel;
        r.wrap = 1'b0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_DIGITS; i++) begin
            cand = sel + SEL_W'(i);
            if (!found && mask[cand]) begin
                r.idx = cand;
                found = 1'b1;
            end
        end
        r.wrap = (r.idx <= sel);
        return r;
    endfunction

    function automatic logic [SEL_W-1:0] first_enabled(input logic [NUM_DIGITS-1:0] mask);
        return next_enabled(SEL_W'(NUM_DIGITS - 1), mask).idx;
    endfunction

endpackage

// File: rtl/digit_scan_sequencer_dwell_prescaler.sv
// Dwell counter: tick is high while cnt sits on its last value (PRESCALE-1).
// tick is decoded from the count register, valid in the same cycle.
// No flow control; clear wins over run.
module dwell_prescaler #(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/digit_scan_sequencer.sv
// Steps a 2-bit digit select through enabled positions, PRESCALE cycles each.
// All outputs registered; sel/sel_valid follow en/digit_mask one cycle later.
// No flow control; the decoder consumes sel every cycle.
module digit_scan_sequencer
    import digit_scan_sequencer_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]      sel,
    output logic                  sel_valid,
    output logic                  frame_done
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             cnt_clear;
    logic             tick;
    logic             scan_ok;
    next_sel_t        nxt;

    assign scan_ok = en && (digit_mask != '0);
    assign nxt     = next_enabled(sel_q, digit_mask);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sel_valid_d  = sel_valid_q;
        frame_done_d = 1'b0;
        cnt_clear    = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d       = '0;
                sel_valid_d = 1'b0;
                cnt_clear   = 1'b1;
                if (scan_ok) begin
                    state_d     = SCAN;
                    sel_d       = first_enabled(digit_mask);
                    sel_valid_d = 1'b1;
                end
            end
            SCAN: begin
                if (!scan_ok) begin
                    state_d     = IDLE;
                    sel_d       = '0;
                    sel_valid_d = 1'b0;
                    cnt_clear   = 1'b1;
                end else if (!digit_mask[sel_q] || tick) begin
                    // A masked current digit is abandoned at once with a fresh dwell.
                    sel_d        = nxt.idx;
                    frame_done_d = nxt.wrap;
                    cnt_clear    = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                sel_d     = '0;
                cnt_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            sel_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            sel_valid_q  <= sel_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    dwell_prescaler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .run   (state_q == SCAN),
        .tick  (tick)
    );

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Bench for digit_scan_sequencer: directed scenarios with literal expectations,
// plus randomized en/mask traffic against a cycle-level reference model.
module tb_digit_scan_sequencer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] digit_mask;
    logic [1:0] sel4, sel1;
    logic       vld4, vld1, fd4, fd1;

    int vectors;
    int miscompares;

    digit_scan_sequencer #(.PRESCALE(4), .CNT_W(16)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digit_mask (digit_mask),
        .sel        (sel4),
        .sel_valid  (vld4),
        .frame_done (fd4)
    );

    digit_scan_sequencer #(.PRESCALE(1), .CNT_W(16)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digit_mask (digit_mask),
        .sel        (sel1),
        .sel_valid  (vld1),
        .frame_done (fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "age" is how many cycles the current digit has been shown.
    typedef struct packed {
        logic       act;
        logic [1:0] sel;
        int         age;
        logic       fd;
    } mstate_t;

    mstate_t m4, m1;

    function automatic mstate_t model_next(input mstate_t s, input int p,
                                           input logic e, input logic [3:0] m);
        mstate_t n;
        int      c;
        bit      found;
        n = s;
        n.fd = 1'b0;
        if (!s.act) begin
            n.sel = 2'd0;
            n.age = 0;
            if (e && m != 4'd0) begin
                n.act = 1'b1;
                found = 0;
                for (int i = 0; i < 4; i++)
                    if (!found && m[i]) begin n.sel = 2'(i); found = 1; end
            end
        end else if (!e || m == 4'd0) begin
            n.act = 1'b0;
            n.sel = 2'd0;
            n.age = 0;
        end else if (!m[s.sel] || s.age == p - 1) begin
            c = int'(s.sel);
            found = 0;
            for (int i = 1; i <= 4; i++)
                if (!found && m[(int'(s.sel) + i) % 4]) begin
                    c = (int'(s.sel) + i) % 4;
                    found = 1;
                end
            n.fd  = (c <= int'(s.sel));
            n.sel = 2'(c);
            n.age = 0;
        end else begin
            n.age = s.age + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 <= '0;
            m1 <= '0;
        end else begin
            m4 <= model_next(m4, 4, en, digit_mask);
            m1 <= model_next(m1, 1, en, digit_mask);
        end
    end

    task automatic go_idle();
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        digit_mask = 4'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (sel4 !== 2'd0 || vld4 !== 1'b0 || fd4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset p4: sel=%0d vld=%0b fd=%0b, expected 0/0/0", sel4, vld4, fd4);
        end
        vectors++;
        if (sel1 !== 2'd0 || vld1 !== 1'b0 || fd1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset p1: sel=%0d vld=%0b fd=%0b, expected 0/0/0", sel1, vld1, fd1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (vld4 !== 1'b0 || sel4 !== 2'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: sel=%0d vld=%0b, expected 0/0", sel4, vld4);
        end
    endtask

    task automatic test_full_scan();
        logic [1:0] e_sel;
        logic       e_fd;
        go_idle();
        en = 1'b1;
        digit_mask = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            e_sel = 2'(((c - 1) / 4) % 4);
            e_fd  = (c == 17);
            vectors++;
            if (sel4 !== e_sel || vld4 !== 1'b1 || fd4 !== e_fd) begin
                miscompares++;
                $display("FAIL full_scan cyc%0d: sel=%0d vld=%0b fd=%0b, expected sel=%0d vld=1 fd=%0b",
                         c, sel4, vld4, fd4, e_sel, e_fd);
            end
        end
    endtask

    task automatic test_sparse_mask();
        logic [1:0] e_sel;
        logic       e_fd;
        go_idle();
        en = 1'b1;
        digit_mask = 4'b1010;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            e_sel = (((c - 1) / 4) % 2 == 0) ? 2'd1 : 2'd3;
            e_fd  = (c > 1) && ((c - 1) % 8 == 0);
            vectors++;
            if (sel4 !== e_sel || vld4 !== 1'b1 || fd4 !== e_fd) begin
                miscompares++;
                $display("FAIL sparse_mask cyc%0d: sel=%0d vld=%0b fd=%0b, expected sel=%0d vld=1 fd=%0b",
                         c, sel4, vld4, fd4, e_sel, e_fd);
            end
        end
    endtask

    task automatic test_single_digit();
        logic e_fd4, e_fd1;
        go_idle();
        en = 1'b1;
        digit_mask = 4'b0100;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            e_fd4 = (c > 1) && ((c - 1) % 4 == 0);
            e_fd1 = (c > 1);
            vectors++;
            if (sel4 !== 2'd2 || vld4 !== 1'b1 || fd4 !== e_fd4) begin
                miscompares++;
                $display("FAIL single_digit p4 cyc%0d: sel=%0d vld=%0b fd=%0b, expected sel=2 vld=1 fd=%0b",
                         c, sel4, vld4, fd4, e_fd4);
            end
            vectors++;
            if (sel1 !== 2'd2 || vld1 !== 1'b1 || fd1 !== e_fd1) begin
                miscompares++;
                $display("FAIL single_digit p1 cyc%0d: sel=%0d vld=%0b fd=%0b, expected sel=2 vld=1 fd=%0b",
                         c, sel1, vld1, fd1, e_fd1);
            end
        end
    endtask

    task automatic test_mask_mid_dwell();
        logic [1:0] e_sel;
        go_idle();
        en = 1'b1;
        digit_mask = 4'b1111;
        repeat (6) @(negedge clk);
        vectors++;
        if (sel4 !== 2'd1) begin
            miscompares++;
            $display("FAIL mask_mid_dwell setup: sel=%0d, expected 1", sel4);
        end
        digit_mask = 4'b1101;
        for (int c = 7; c <= 11; c++) begin
            @(negedge clk);
            e_sel = (c <= 10) ? 2'd2 : 2'd3;
            vectors++;
            if (sel4 !== e_sel || vld4 !== 1'b1 || fd4 !== 1'b0) begin
                miscompares++;
                $display("FAIL mask_mid_dwell cyc%0d: sel=%0d vld=%0b fd=%0b, expected sel=%0d vld=1 fd=0",
                         c, sel4, vld4, fd4, e_sel);
            end
        end
    endtask

    task automatic test_en_drop();
        go_idle();
        en = 1'b1;
        digit_mask = 4'b1111;
        repeat (14) @(negedge clk);
        vectors++;
        if (sel4 !== 2'd3) begin
            miscompares++;
            $display("FAIL en_drop setup: sel=%0d, expected 3", sel4);
        end
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (sel4 !== 2'd0 || vld4 !== 1'b0 || fd4 !== 1'b0) begin
            miscompares++;
            $display("FAIL en_drop idle: sel=%0d vld=%0b fd=%0b, expected 0/0/0", sel4, vld4, fd4);
        end
        en = 1'b1;
        digit_mask = 4'b1000;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            vectors++;
            if (sel4 !== 2'd3 || vld4 !== 1'b1 || fd4 !== (c == 5)) begin
                miscompares++;
                $display("FAIL en_drop reentry cyc%0d: sel=%0d vld=%0b fd=%0b, expected sel=3 vld=1 fd=%0b",
                         c, sel4, vld4, fd4, (c == 5));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] e_sel;
        go_idle();
        en = 1'b1;
        digit_mask = 4'b1111;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (sel4 !== 2'd0 || vld4 !== 1'b0 || fd4 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset p4: sel=%0d vld=%0b fd=%0b, expected 0/0/0", sel4, vld4, fd4);
        end
        vectors++;
        if (sel1 !== 2'd0 || vld1 !== 1'b0 || fd1 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset p1: sel=%0d vld=%0b fd=%0b, expected 0/0/0", sel1, vld1, fd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            e_sel = (c <= 4) ? 2'd0 : 2'd1;
            vectors++;
            if (sel4 !== e_sel || vld4 !== 1'b1 || fd4 !== 1'b0) begin
                miscompares++;
                $display("FAIL async_restart cyc%0d: sel=%0d vld=%0b fd=%0b, expected sel=%0d vld=1 fd=0",
                         c, sel4, vld4, fd4, e_sel);
            end
        end
    endtask

    task automatic test_random();
        en = 1'b1;
        digit_mask = 4'b1111;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            vectors++;
            if (sel4 !== m4.sel || vld4 !== m4.act || fd4 !== m4.fd) begin
                miscompares++;
                $display("FAIL random p4 cyc%0d: sel=%0d vld=%0b fd=%0b, expected sel=%0d vld=%0b fd=%0b",
                         c, sel4, vld4, fd4, m4.sel, m4.act, m4.fd);
            end
            vectors++;
            if (sel1 !== m1.sel || vld1 !== m1.act || fd1 !== m1.fd) begin
                miscompares++;
                $display("FAIL random p1 cyc%0d: sel=%0d vld=%0b fd=%0b, expected sel=%0d vld=%0b fd=%0b",
                         c, sel1, vld1, fd1, m1.sel, m1.act, m1.fd);
            end
            if ($urandom_range(0, 24) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0) digit_mask = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        en          = 1'b0;
        digit_mask  = 4'd0;
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_single_digit();
        test_mask_mid_dwell();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
